// File: rtl/unified_mem_arbiter.sv
// Shares one single-port fixed-latency SRAM between the IF and MEM requesters.
// Optional macro ARB_STARVE_GUARD_EN bounds how long data traffic can starve IF.
module unified_mem_arbiter #(
    parameter int          WAIT_CYCLES  = 4,
    parameter logic [31:0] BASE_ADDR    = 32'h400,
    parameter int          SRAM_AW      = 16,
    parameter int          STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req,
    input  logic [31:0]        if_addr,
    output logic [31:0]        if_rdata,
    output logic               if_ready,
    input  logic               mem_rd_req,
    input  logic               mem_wr_req,
    input  logic [31:0]        mem_addr,
    input  logic [31:0]        mem_wdata,
    output logic [31:0]        mem_rdata,
    output logic               mem_ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [31:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [31:0]        sram_dq_in,
    output logic               sram_ce_n,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t       state;
    logic         grant_data;
    logic         op_wr;
    logic [3:0]   cnt;

    logic               data_req;
    logic               pick_data;
    logic               sel_wr;
    logic               in_range;
    logic [31:0]        sel_addr;
    logic [31:0]        offset;
    logic [SRAM_AW-1:0] sel_word;

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt;
`endif

    always_comb begin
        data_req = mem_rd_req | mem_wr_req;
`ifdef ARB_STARVE_GUARD_EN
        pick_data = data_req && !(if_req && (starve_cnt == 4'(STARVE_LIMIT)));
`else
        pick_data = data_req;
`endif
        // A simultaneous read and write request is served as a write.
        sel_wr   = pick_data && mem_wr_req;
        sel_addr = pick_data ? mem_addr : if_addr;
        offset   = sel_addr - BASE_ADDR;
        // offset < 4 * 2^SRAM_AW is the same as word < 2^SRAM_AW, with addr[1:0] ignored.
        in_range = (sel_addr >= BASE_ADDR) && ({1'b0, offset} < (33'd4 << SRAM_AW));
        sel_word = offset[SRAM_AW+1:2];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            grant_data  <= 1'b0;
            op_wr       <= 1'b0;
            cnt         <= 4'd0;
            if_rdata    <= 32'h0;
            mem_rdata   <= 32'h0;
            if_ready    <= 1'b0;
            mem_ready   <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= 32'h0;
            sram_dq_oe  <= 1'b0;
            sram_ce_n   <= 1'b1;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_req || if_req) begin
                        grant_data <= pick_data;
                        op_wr      <= sel_wr;
                        cnt        <= 4'(WAIT_CYCLES - 1);
                        busy       <= 1'b1;
                        if (in_range) begin
                            state     <= ACCESS;
                            sram_ce_n <= 1'b0;
                            sram_addr <= sel_word;
                            sram_oe_n <= sel_wr;
                            sram_we_n <= !sel_wr;
                            sram_dq_oe <= sel_wr;
                            if (sel_wr) begin
                                sram_dq_out <= mem_wdata;
                            end
                        end else begin
                            // Unmapped address: answer at once, reads return zero, writes vanish.
                            state <= DONE;
                            if (pick_data) begin
                                mem_ready <= 1'b1;
                                if (!sel_wr) begin
                                    mem_rdata <= 32'h0;
                                end
                            end else begin
                                if_ready <= 1'b1;
                                if_rdata <= 32'h0;
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        state      <= DONE;
                        sram_ce_n  <= 1'b1;
                        sram_we_n  <= 1'b1;
                        sram_oe_n  <= 1'b1;
                        sram_dq_oe <= 1'b0;
                        if (grant_data) begin
                            mem_ready <= 1'b1;
                            if (!op_wr) begin
                                mem_rdata <= sram_dq_in;
                            end
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= sram_dq_in;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    if_ready  <= 1'b0;
                    mem_ready <= 1'b0;
                    busy      <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARB_STARVE_GUARD_EN
    // Counts data grants that jumped a waiting IF request; any IF grant ends the streak.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= 4'd0;
        end else if (state == IDLE && (data_req || if_req)) begin
            if (!pick_data) begin
                starve_cnt <= 4'd0;
            end else if (if_req) begin
                if (starve_cnt != 4'hF) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else begin
                starve_cnt <= 4'd0;
            end
        end
    end
`endif

endmodule
